hough_bram_scheduler: RTL and testbench

Frame-level controller and read-port arbiter for the hysteresis BRAM in the Hough lane-detection pipeline. It sits between the hysteresis stage, which fills the BRAM and pulses `hough_start`, and the two consumers of the single BRAM read port: the Hough accumulator reader (requester A) and the BRAM-to-FIFO output streamer (requester B). It sequences each frame by starting both consumers and sharing the read port round-robin. It returns each read result to its owner at fixed latency, and issues `hysteresis_read_done` only after both consumers finish and all in-flight reads have drained.

---
 rtl/hough_pkg.sv | 22 ++
 rtl/rr_arbiter2.sv | 39 +++
 rtl/hough_bram_scheduler.sv | 142 ++++++++++++++
 tb/tb_hough_bram_scheduler.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hough_pkg.sv
// Shared types and image constants for the Hough lane-detection pipeline.
package hough_pkg;

    localparam int unsigned WIDTH  = 512;
    localparam int unsigned HEIGHT = 288;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ACTIVE,
        DRAIN,
        RELEASE
    } sched_state_t;

    // Owner of a BRAM read that is in flight
    typedef enum logic [1:0] {
        TAG_NONE = 2'b00,
        TAG_A    = 2'b01,
        TAG_B    = 2'b10
    } req_tag_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a combinational grant and a last-winner register.
module rr_arbiter2 (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic elig_a,
    input  logic elig_b,
    output logic gnt_a,
    output logic gnt_b
);

    // 1 when B won the most recent grant; starts at B so A wins the first tie
    logic last_b;

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (en) begin
            if (elig_a && elig_b) begin
                gnt_a = last_b;
                gnt_b = ~last_b;
            end else begin
                gnt_a = elig_a;
                gnt_b = elig_b;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_b <= 1'b1;
        end else if (gnt_a) begin
            last_b <= 1'b0;
        end else if (gnt_b) begin
            last_b <= 1'b1;
        end
    end

endmodule

// File: rtl/hough_bram_scheduler.sv
// Frame sequencer and round-robin read-port arbiter for the hysteresis BRAM,
// returning each read to its owner at fixed latency.
module hough_bram_scheduler
    import hough_pkg::*;
#(
    parameter int unsigned WIDTH        = 512,
    parameter int unsigned HEIGHT       = 288,
    parameter int unsigned ADDR_BITS    = $clog2(WIDTH * HEIGHT),
    parameter int unsigned BRAM_LATENCY = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 hough_start,
    output logic                 hysteresis_read_done,
    output logic                 consumer_start,
    input  logic                 req_a,
    input  logic                 req_b,
    input  logic [ADDR_BITS-1:0] addr_a,
    input  logic [ADDR_BITS-1:0] addr_b,
    output logic                 gnt_a,
    output logic                 gnt_b,
    input  logic                 done_a,
    input  logic                 done_b,
    output logic                 valid_a,
    output logic                 valid_b,
    output logic [7:0]           rd_data,
    output logic [ADDR_BITS-1:0] bram_rd_addr,
    input  logic [7:0]           bram_rd_data,
    output logic                 busy,
    output logic [15:0]          frame_count
);

    sched_state_t         state;
    sched_state_t         state_next;
    logic                 pending;
    logic                 done_a_seen;
    logic                 done_b_seen;
    logic [ADDR_BITS-1:0] addr_hold;
    req_tag_t             tags [BRAM_LATENCY];
    req_tag_t             tag_in;
    logic                 drained;

    rr_arbiter2 u_arb (
        .clock  (clock),
        .reset  (reset),
        .en     (state == ACTIVE),
        .elig_a (req_a & ~done_a_seen),
        .elig_b (req_b & ~done_b_seen),
        .gnt_a  (gnt_a),
        .gnt_b  (gnt_b)
    );

    // Idle cycles hold the last address so the BRAM address bus stays quiet
    assign bram_rd_addr = gnt_a ? addr_a : (gnt_b ? addr_b : addr_hold);
    assign rd_data      = bram_rd_data;
    assign valid_a      = (tags[BRAM_LATENCY-1] == TAG_A);
    assign valid_b      = (tags[BRAM_LATENCY-1] == TAG_B);

    always_comb begin
        tag_in = TAG_NONE;
        if (gnt_a) begin
            tag_in = TAG_A;
        end else if (gnt_b) begin
            tag_in = TAG_B;
        end
    end

    // The output stage may still be delivering its last read; release follows next cycle
    always_comb begin
        drained = 1'b1;
        for (int i = 0; i < int'(BRAM_LATENCY) - 1; i++) begin
            if (tags[i] != TAG_NONE) begin
                drained = 1'b0;
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (hough_start || pending) state_next = START;
            START:   state_next = ACTIVE;
            ACTIVE:  if ((done_a_seen || done_a) && (done_b_seen || done_b)) state_next = DRAIN;
            DRAIN:   if (drained) state_next = RELEASE;
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending              <= 1'b0;
            done_a_seen          <= 1'b0;
            done_b_seen          <= 1'b0;
            addr_hold            <= '0;
            consumer_start       <= 1'b0;
            hysteresis_read_done <= 1'b0;
            busy                 <= 1'b0;
            frame_count          <= 16'd0;
            for (int i = 0; i < int'(BRAM_LATENCY); i++) begin
                tags[i] <= TAG_NONE;
            end
        end else begin
            // A start arriving during START itself must not be lost by the clear
            if (state == START) begin
                pending <= hough_start;
            end else if (state != IDLE && hough_start) begin
                pending <= 1'b1;
            end

            if (state == START) begin
                done_a_seen <= 1'b0;
                done_b_seen <= 1'b0;
            end else if (state == ACTIVE) begin
                done_a_seen <= done_a_seen | done_a;
                done_b_seen <= done_b_seen | done_b;
            end

            addr_hold            <= bram_rd_addr;
            consumer_start       <= (state_next == START);
            hysteresis_read_done <= (state_next == RELEASE);
            busy                 <= (state_next != IDLE);
            if (state_next == RELEASE) begin
                frame_count <= frame_count + 16'd1;
            end

            tags[0] <= tag_in;
            for (int i = 1; i < int'(BRAM_LATENCY); i++) begin
                tags[i] <= tags[i-1];
            end
        end
    end

endmodule

// File: tb/tb_hough_bram_scheduler.sv
// Directed bench for hough_bram_scheduler with a 3-cycle BRAM and hand-derived cycle expectations.
module tb_hough_bram_scheduler;

    localparam int unsigned AB = 18;

    logic          clock = 1'b0;
    logic          reset;
    logic          hough_start;
    logic          hysteresis_read_done;
    logic          consumer_start;
    logic          req_a, req_b;
    logic [AB-1:0] addr_a, addr_b;
    logic          gnt_a, gnt_b;
    logic          done_a, done_b;
    logic          valid_a, valid_b;
    logic [7:0]    rd_data;
    logic [AB-1:0] bram_rd_addr;
    logic [7:0]    bram_rd_data;
    logic          busy;
    logic [15:0]   frame_count;

    int n_cmp = 0;
    int n_err = 0;

    hough_bram_scheduler #(
        .WIDTH(512), .HEIGHT(288), .ADDR_BITS(AB), .BRAM_LATENCY(3)
    ) dut (
        .clock(clock), .reset(reset), .hough_start(hough_start),
        .hysteresis_read_done(hysteresis_read_done), .consumer_start(consumer_start),
        .req_a(req_a), .req_b(req_b), .addr_a(addr_a), .addr_b(addr_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
        .valid_a(valid_a), .valid_b(valid_b), .rd_data(rd_data),
        .bram_rd_addr(bram_rd_addr), .bram_rd_data(bram_rd_data),
        .busy(busy), .frame_count(frame_count)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] mem_f(input logic [AB-1:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    // Three-cycle synchronous-read BRAM
    logic [7:0] bram_pipe [3];
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            bram_pipe[0] <= 8'd0;
            bram_pipe[1] <= 8'd0;
            bram_pipe[2] <= 8'd0;
        end else begin
            bram_pipe[0] <= mem_f(bram_rd_addr);
            bram_pipe[1] <= bram_pipe[0];
            bram_pipe[2] <= bram_pipe[1];
        end
    end
    assign bram_rd_data = bram_pipe[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        hough_start = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        done_a = 1'b0;
        done_b = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt_a"}, 32'(gnt_a), 32'd0);
        check({tag, "_gnt_b"}, 32'(gnt_b), 32'd0);
        check({tag, "_valid_a"}, 32'(valid_a), 32'd0);
        check({tag, "_valid_b"}, 32'(valid_b), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_cstart"}, 32'(consumer_start), 32'd0);
        check({tag, "_rdone"}, 32'(hysteresis_read_done), 32'd0);
        check({tag, "_fcount"}, 32'(frame_count), 32'd0);
        check({tag, "_addr"}, 32'(bram_rd_addr), 32'd0);
    endtask

    // Pulse hough_start and confirm consumer_start follows one cycle later
    task automatic start_frame(input string tag);
        @(negedge clock);
        hough_start = 1'b1;
        #1;
        check({tag, "_cstart_pre"}, 32'(consumer_start), 32'd0);
        @(negedge clock);
        hough_start = 1'b0;
        #1;
        check({tag, "_cstart"}, 32'(consumer_start), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    initial begin
        logic        ev_a, ev_b;
        logic [31:0] exp_addr;

        reset = 1'b1;
        addr_a = '0;
        addr_b = '0;
        clear_inputs();
        @(negedge clock);
        @(negedge clock);
        #1;
        check_all_zero("reset");
        @(negedge clock);
        reset = 1'b0;

        // Contention frame; a second start arrives mid-frame and both dones land on the last grant
        start_frame("cont");
        for (int k = 0; k < 14; k++) begin
            @(negedge clock);
            req_a = (k < 8);
            req_b = (k < 8);
            addr_a = AB'(100 + k);
            addr_b = AB'(200 + k);
            hough_start = (k == 2);
            done_a = (k == 7);
            done_b = (k == 7);
            #1;
            check("cont_gnt_a", 32'(gnt_a), 32'((k < 8) && (k % 2 == 0)));
            check("cont_gnt_b", 32'(gnt_b), 32'((k < 8) && (k % 2 == 1)));
            if (k < 8) begin
                exp_addr = (k % 2 == 0) ? 32'(100 + k) : 32'(200 + k);
                check("cont_addr", 32'(bram_rd_addr), exp_addr);
            end
            ev_a = (k >= 3) && (k < 11) && ((k - 3) % 2 == 0);
            ev_b = (k >= 3) && (k < 11) && ((k - 3) % 2 == 1);
            check("cont_valid_a", 32'(valid_a), 32'(ev_a));
            check("cont_valid_b", 32'(valid_b), 32'(ev_b));
            if (ev_a) check("cont_data_a", 32'(rd_data), 32'(mem_f(AB'(100 + k - 3))));
            if (ev_b) check("cont_data_b", 32'(rd_data), 32'(mem_f(AB'(200 + k - 3))));
            check("cont_rdone", 32'(hysteresis_read_done), 32'(k == 11));
            check("cont_fcount", 32'(frame_count), (k >= 11) ? 32'd1 : 32'd0);
            check("cont_busy", 32'(busy), 32'(k != 12));
            check("pend_cstart", 32'(consumer_start), 32'(k == 13));
        end
        clear_inputs();

        // Pending frame: A reads 0..15, B finishes at once
        for (int j = 0; j < 22; j++) begin
            @(negedge clock);
            req_a = (j < 16);
            addr_a = AB'(j);
            done_b = (j == 0);
            done_a = (j == 16);
            #1;
            check("aonly_gnt_a", 32'(gnt_a), 32'(j < 16));
            check("aonly_gnt_b", 32'(gnt_b), 32'd0);
            if (j < 16) check("aonly_addr", 32'(bram_rd_addr), 32'(j));
            ev_a = (j >= 3) && (j < 19);
            check("aonly_valid_a", 32'(valid_a), 32'(ev_a));
            check("aonly_valid_b", 32'(valid_b), 32'd0);
            if (ev_a) check("aonly_data", 32'(rd_data), 32'(mem_f(AB'(j - 3))));
            check("aonly_rdone", 32'(hysteresis_read_done), 32'(j == 19));
            check("aonly_fcount", 32'(frame_count), (j >= 19) ? 32'd2 : 32'd1);
            check("aonly_busy", 32'(busy), 32'(j < 20));
        end
        clear_inputs();

        // Stray requests and dones while idle
        for (int s = 0; s < 3; s++) begin
            @(negedge clock);
            req_a = 1'b1;
            req_b = 1'b1;
            done_a = 1'b1;
            done_b = 1'b1;
            addr_a = AB'(9);
            #1;
            check("idle_gnt_a", 32'(gnt_a), 32'd0);
            check("idle_gnt_b", 32'(gnt_b), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_cstart", 32'(consumer_start), 32'd0);
        end
        clear_inputs();

        // Done with request in the same cycle, then A locked out, then reset with reads in flight
        start_frame("f3");
        @(negedge clock);
        req_a = 1'b1; addr_a = AB'(5); done_a = 1'b1;
        #1;
        check("f3_gnt_a_done_same", 32'(gnt_a), 32'd1);
        check("f3_addr0", 32'(bram_rd_addr), 32'd5);
        @(negedge clock);
        done_a = 1'b0; addr_a = AB'(6);
        #1;
        check("f3_gnt_a_after_done", 32'(gnt_a), 32'd0);
        check("f3_addr_hold", 32'(bram_rd_addr), 32'd5);
        @(negedge clock);
        req_b = 1'b1; addr_b = AB'(7);
        #1;
        check("f3_gnt_a_locked", 32'(gnt_a), 32'd0);
        check("f3_gnt_b", 32'(gnt_b), 32'd1);
        check("f3_addr_b", 32'(bram_rd_addr), 32'd7);
        @(negedge clock);
        addr_b = AB'(8);
        #1;
        check("f3_gnt_b2", 32'(gnt_b), 32'd1);
        check("f3_valid_a", 32'(valid_a), 32'd1);
        check("f3_data_a", 32'(rd_data), 32'(mem_f(AB'(5))));
        check("f3_fcount", 32'(frame_count), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        clear_inputs();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int p = 0; p < 6; p++) begin
            @(negedge clock);
            #1;
            check("post_valid_a", 32'(valid_a), 32'd0);
            check("post_valid_b", 32'(valid_b), 32'd0);
            check("post_rdone", 32'(hysteresis_read_done), 32'd0);
            check("post_busy", 32'(busy), 32'd0);
        end

        // Clean frame after reset: A reads 40 and 41
        start_frame("clean");
        for (int k = 0; k < 7; k++) begin
            @(negedge clock);
            req_a = (k < 2);
            addr_a = AB'(40 + k);
            done_b = (k == 0);
            done_a = (k == 1);
            #1;
            check("clean_gnt_a", 32'(gnt_a), 32'(k < 2));
            ev_a = (k == 3) || (k == 4);
            check("clean_valid_a", 32'(valid_a), 32'(ev_a));
            check("clean_valid_b", 32'(valid_b), 32'd0);
            if (ev_a) check("clean_data", 32'(rd_data), 32'(mem_f(AB'(40 + k - 3))));
            check("clean_rdone", 32'(hysteresis_read_done), 32'(k == 5));
            check("clean_fcount", 32'(frame_count), (k >= 5) ? 32'd1 : 32'd0);
            check("clean_busy", 32'(busy), 32'(k < 6));
        end
        clear_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
